// File: rtl/fanin_rr_arbiter.sv
// fanin_rr_arbiter
//   Two-input fan-in stage feeding the 2:1 flit mux. Each input stream is
//   buffered in a small FIFO. Arbitration is round-robin at packet granularity,
//   so a multi-flit packet is never interleaved with the other input. The output
//   flit is registered and uses valid/ready flow control.
//
// Ports
//   clk                      rising-edge clock
//   rst_n                    synchronous reset, active low
//   inX_data/_tail/_valid    input X flit, last-flit flag and valid
//   inX_ready                input X FIFO can take a flit (count-based only)
//   out_data/_tail/_valid    registered output flit
//   out_ready                downstream accepts out_data this cycle
//   sel                      source input of the current out_data (mux select)
module fanin_rr_arbiter #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_tail,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_tail,
  input  logic              in1_valid,
  output logic              in1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_tail,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } state_e;

  // Per-input views; bit/element index is the input number.
  logic [1:0]      in_valid;
  logic [1:0]      in_ready;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      nonempty;
  logic [DATA_W:0] in_flit [2];
  logic [DATA_W:0] head    [2];

  assign in_valid   = {in1_valid, in0_valid};
  assign in_flit[0] = {in0_tail, in0_data};
  assign in_flit[1] = {in1_tail, in1_data};
  assign in0_ready  = in_ready[0];
  assign in1_ready  = in_ready[1];

  // Input FIFOs, entries stored as {tail, data}.
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DATA_W:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign nonempty[g] = (cnt_q != '0);
    // Ready looks at count only: a full FIFO is not ready even while popping.
    assign in_ready[g] = rst_n & (cnt_q != FULL);
    assign push[g]     = in_valid[g] & in_ready[g];
    assign head[g]     = mem_q[rd_q];

    always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push[g]) wr_d = wr_q + PTR_W'(1);
      if (pop[g])  rd_d = rd_q + PTR_W'(1);
      if (push[g] && !pop[g])      cnt_d = cnt_q + CNT_W'(1);
      else if (!push[g] && pop[g]) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push[g]) mem_q[wr_q] <= in_flit[g];
    end
  end

  // Arbitration and output register.
  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_tail_q, out_tail_d;
  logic              sel_q, sel_d;

  logic            load_en;
  logic            gnt_v;
  logic            gnt;
  logic            xfer;
  logic [DATA_W:0] head_sel;

  assign load_en  = ~out_valid_q | out_ready;
  assign xfer     = load_en & gnt_v;
  assign pop      = {xfer & gnt, xfer & ~gnt};
  assign head_sel = head[gnt];

  always_comb begin
    gnt_v = 1'b0;
    gnt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (nonempty[0] && nonempty[1]) begin
          gnt_v = 1'b1;
          gnt   = prio_q;
        end else if (nonempty[0] || nonempty[1]) begin
          gnt_v = 1'b1;
          gnt   = nonempty[1];
        end
      end
      // While locked, an empty FIFO yields a bubble rather than a switch.
      LOCK0: gnt_v = nonempty[0];
      LOCK1: begin
        gnt_v = nonempty[1];
        gnt   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tail_d  = out_tail_q;
    sel_d       = sel_q;
    if (load_en) begin
      out_valid_d = gnt_v;
      if (gnt_v) begin
        {out_tail_d, out_data_d} = head_sel;
        sel_d = gnt;
        if (head_sel[DATA_W]) begin
          state_d = IDLE;
          prio_d  = ~gnt;
        end else begin
          state_d = gnt ? LOCK1 : LOCK0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tail_q  <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tail_q  <= out_tail_d;
      sel_q       <= sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tail  = out_tail_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_fanin_rr_arbiter.sv
// Testbench for fanin_rr_arbiter: directed vector table plus a backpressure
// sequence checked against per-input queues of accepted flits.
module tb_fanin_rr_arbiter;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in0_data, in1_data, out_data;
  logic          in0_tail, in0_valid, in0_ready;
  logic          in1_tail, in1_valid, in1_ready;
  logic          out_tail, out_valid, out_ready, sel;

  always #5 clk = ~clk;

  fanin_rr_arbiter #(
    .DATA_W    (DW),
    .FIFO_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0_data (in0_data),
    .in0_tail (in0_tail),
    .in0_valid(in0_valid),
    .in0_ready(in0_ready),
    .in1_data (in1_data),
    .in1_tail (in1_tail),
    .in1_valid(in1_valid),
    .in1_ready(in1_ready),
    .out_data (out_data),
    .out_tail (out_tail),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel      (sel)
  );

  typedef struct packed {
    logic       rst_n;
    logic       v0;
    logic [7:0] d0;
    logic       t0;
    logic       v1;
    logic [7:0] d1;
    logic       t1;
    logic       ordy;
    logic       ov;
    logic [7:0] od;
    logic       ot;
    logic       sel;
    logic       r0;
    logic       r1;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic r, input logic v0, input logic [7:0] d0,
                              input logic t0, input logic v1, input logic [7:0] d1,
                              input logic t1, input logic ordy, input logic ov,
                              input logic [7:0] od, input logic ot, input logic s,
                              input logic r0, input logic r1);
    mk = '{r, v0, d0, t0, v1, d1, t1, ordy, ov, od, ot, s, r0, r1};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic v0, input logic [7:0] d0, input logic t0,
                       input logic v1, input logic [7:0] d1, input logic t1, input logic ordy);
    rst_n     = r;
    in0_valid = v0;
    in0_data  = 64'(d0);
    in0_tail  = t0;
    in1_valid = v1;
    in1_data  = 64'(d1);
    in1_tail  = t1;
    out_ready = ordy;
  endtask

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_d;
  logic       acc0, acc1;

  initial begin
    //          r  v0 d0     t0 v1 d1     t1 rdy | ov od     ot sel r0 r1
    // reset held with in0 driving
    tbl.push_back(mk(0, 1, 8'h11, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h11, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h11, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1, 1));
    // single 1-flit packet on in0, two-cycle latency
    tbl.push_back(mk(1, 1, 8'hA5, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'hA5, 1, 0, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'hA5, 1, 0, 1, 1));
    // round-robin between continuous 1-flit streams (sources hold until accepted)
    tbl.push_back(mk(1, 1, 8'h01, 1, 1, 8'h81, 1, 1, 0, 8'hA5, 1, 0, 1, 1));
    tbl.push_back(mk(1, 1, 8'h02, 1, 1, 8'h82, 1, 1, 1, 8'h81, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 8'h03, 1, 1, 8'h83, 1, 1, 1, 8'h01, 1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 8'h03, 1, 1, 8'h84, 1, 1, 1, 8'h82, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 8'h04, 1, 1, 8'h84, 1, 1, 1, 8'h02, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'h83, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'h03, 1, 0, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'h84, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h84, 1, 1, 1, 1));
    // packet lock: 3-flit in0 packet with a gap, in1 packets waiting
    tbl.push_back(mk(1, 1, 8'h10, 0, 1, 8'h90, 1, 1, 0, 8'h84, 1, 1, 1, 1));
    tbl.push_back(mk(1, 1, 8'h11, 0, 1, 8'h91, 1, 1, 1, 8'h10, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h92, 1, 1, 1, 8'h11, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h92, 1, 1, 0, 8'h11, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 8'h12, 1, 1, 8'h92, 1, 1, 0, 8'h11, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h92, 1, 1, 1, 8'h12, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'h90, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'h91, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h91, 1, 1, 1, 1));
    // reset in the middle of a 3-flit in1 packet; in0 then wins a tie
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'hC0, 0, 1, 0, 8'h91, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'hC1, 0, 1, 1, 8'hC0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'hC2, 1, 1, 1, 8'hC1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 8'hD0, 1, 1, 8'hE0, 1, 1, 0, 8'h00, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'hD0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'hE0, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'hE0, 1, 1, 1, 1));

    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].v0, tbl[i].d0, tbl[i].t0,
            tbl[i].v1, tbl[i].d1, tbl[i].t1, tbl[i].ordy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("v%0d.out_data", i),  out_data,       64'(tbl[i].od));
      chk($sformatf("v%0d.out_tail", i),  64'(out_tail),  64'(tbl[i].ot));
      chk($sformatf("v%0d.sel", i),       64'(sel),       64'(tbl[i].sel));
      chk($sformatf("v%0d.in0_ready", i), 64'(in0_ready), 64'(tbl[i].r0));
      chk($sformatf("v%0d.in1_ready", i), 64'(in1_ready), 64'(tbl[i].r1));
    end

    // Backpressure: out_ready low for 6 cycles with both inputs streaming
    // 1-flit packets; DUT is IDLE, prio 0, FIFOs and output empty here.
    drive(1, 1, 8'h20, 1, 1, 8'hB0, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      acc0 = in0_valid & in0_ready;
      acc1 = in1_valid & in1_ready;
      if (acc0) q0.push_back(in0_data[7:0]);
      if (acc1) q1.push_back(in1_data[7:0]);
      @(posedge clk);
      #1;
      if (acc0) in0_data = in0_data + 64'd1;
      if (acc1) in1_data = in1_data + 64'd1;
      chk($sformatf("bp%0d.in0_ready", k), 64'(in0_ready), (k <= 2) ? 64'd1 : 64'd0);
      chk($sformatf("bp%0d.in1_ready", k), 64'(in1_ready), (k == 1) ? 64'd1 : 64'd0);
      chk($sformatf("bp%0d.out_valid", k), 64'(out_valid), (k >= 2) ? 64'd1 : 64'd0);
      if (k >= 2) begin
        chk($sformatf("bp%0d.out_data", k), out_data,       64'h20);
        chk($sformatf("bp%0d.sel", k),      64'(sel),       64'd0);
        chk($sformatf("bp%0d.out_tail", k), 64'(out_tail),  64'd1);
      end
    end
    chk("bp.in0_accepted", 64'(q0.size()), 64'd3);
    chk("bp.in1_accepted", 64'(q1.size()), 64'd2);

    // Release and drain: each consumed flit must be the oldest accepted one
    // of the input named by sel.
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) begin
        if (sel ? (q1.size() == 0) : (q0.size() == 0)) begin
          chk($sformatf("drain%0d.extra_flit", c), out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_d = sel ? q1.pop_front() : q0.pop_front();
          chk($sformatf("drain%0d.out_data", c), out_data, 64'(exp_d));
        end
      end
      @(posedge clk);
      #1;
    end
    chk("drain.in0_left", 64'(q0.size()), 64'd0);
    chk("drain.in1_left", 64'(q1.size()), 64'd0);
    chk("drain.out_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
